// File: rtl/mod461_chunk_accumulator_if.sv
// Handshake bundle for the mod-461 chunk accumulator: term input stream and residue output stream.
// The slave side is the accumulator; the master side is whatever feeds it and takes its results.
interface mod461_chunk_accumulator_if #(
  parameter int W = 9
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_residue;
  logic         out_err;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_residue, out_err
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_residue, out_err
  );
endinterface

// File: rtl/mod461_chunk_accumulator.sv
// Streaming modulo-MODULUS accumulator over NUM_TERMS chunk residues per operand.
// It flags out-of-range terms and framing errors, then presents the residue on a valid/ready beat.
module mod461_chunk_accumulator #(
  parameter int MODULUS   = 461,
  parameter int W         = 9,
  parameter int NUM_TERMS = 67,
  parameter int CNT_W     = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  mod461_chunk_accumulator_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [W:0]       MOD_C    = (W+1)'(MODULUS);
  localparam logic [CNT_W-1:0] TERMS_C  = CNT_W'(NUM_TERMS);
  localparam bit               ONE_TERM = (NUM_TERMS == 1);

  state_t           state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [W:0]       data_ext, data_sub, sum, sum_sub;
  logic [W-1:0]     d, acc_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             range_err, last_term, in_fire, out_fire;

  // Both operands of the sum are already below MODULUS, so one conditional subtract reduces it.
  assign data_ext  = {1'b0, bus.in_data};
  assign range_err = (data_ext >= MOD_C);
  assign data_sub  = data_ext - MOD_C;
  assign d         = range_err ? data_sub[W-1:0] : bus.in_data;
  assign sum       = {1'b0, acc_q} + {1'b0, d};
  assign sum_sub   = sum - MOD_C;
  assign acc_next  = (sum >= MOD_C) ? sum_sub[W-1:0] : sum[W-1:0];

  assign cnt_inc   = cnt_q + 1'b1;
  assign last_term = (cnt_inc == TERMS_C);

  // Ready depends only on state (gated low while reset is held), never on in_valid.
  assign bus.in_ready    = (state_q != DONE) && !rst;
  assign bus.out_valid   = (state_q == DONE);
  assign bus.out_residue = acc_q;
  assign bus.out_err     = err_q;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          acc_d   = d;
          cnt_d   = CNT_W'(1);
          err_d   = range_err;
          state_d = (bus.in_last || ONE_TERM) ? DONE : ACC;
        end
      end
      ACC: begin
        if (in_fire) begin
          acc_d = acc_next;
          cnt_d = cnt_inc;
          // Early last and missing last both reduce to in_last disagreeing with the term count.
          err_d = err_q || range_err || (bus.in_last != last_term);
          if (bus.in_last || last_term) state_d = DONE;
        end
      end
      DONE: begin
        if (out_fire) begin
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/mod461_chunk_accumulator.md
Name: mod461_chunk_accumulator

Overview:
- Streaming modular accumulator directly downstream of the 6-input/9-output chunk-residue LUT stage of the mod-461 datapath for 400-bit operands.
- Each LUT stage maps one 6-bit operand chunk to its residue contribution, a 9-bit value in 0..460.
- This block consumes one contribution per handshake and sums them modulo 461 over a full operand of NUM_TERMS chunks.
- It then presents the final 9-bit residue with a valid/ready handshake.

Parameters:
- MODULUS, 461, modulus; must satisfy 2^(W-1) < MODULUS < 2^W.
- W, 9, residue width.
- NUM_TERMS, 67, chunks per operand (ceil(400/6)).
- CNT_W, 7, counter width; must satisfy 2^CNT_W > NUM_TERMS.

Ports:
- clk, in, 1, single clock; all state updates on its rising edge.
- rst, in, 1, synchronous, active-high reset.
- in_valid, in, 1, upstream term valid.
- in_ready, out, 1, block can accept a term.
- in_data, in, W, chunk residue contribution.
- in_last, in, 1, marks the final term of an operand.
- out_valid, out, 1, result valid.
- out_ready, in, 1, downstream accepts the result.
- out_residue, out, W, accumulated sum mod MODULUS.
- out_err, out, 1, framing or range error seen in this operand.

Behaviour:
- Interface:
  - One clock (clk).
  - Reset (rst) is synchronous and active-high.
  - No other clock or asynchronous input.
- Reset values: state=IDLE, acc=0, cnt=0, err=0, in_ready=0 during the reset cycle, out_valid=0, out_residue=0, out_err=0.
- Transfers:
  - An input beat transfers when in_valid & in_ready.
  - An output beat transfers when out_valid & out_ready.
- Input pre-reduction:
  - d = (in_data >= MODULUS) ? in_data - MODULUS : in_data, so d is in 0..460.
  - in_data >= MODULUS also sets err.
- Accumulate:
  - s = acc + d, computed at W+1 bits.
  - acc_next = (s >= MODULUS) ? s - MODULUS : s.
  - One conditional subtract suffices because acc and d are both < MODULUS.
  - Purely combinational within the cycle; no multi-cycle reduction.
- State machine:
  - IDLE:
    - in_ready=1.
    - On transfer: acc <= d (reduced), cnt <= 1, err <= range flag.
    - If in_last, or NUM_TERMS==1, go to DONE; else go to ACC.
  - ACC:
    - in_ready=1.
    - On transfer: acc <= acc_next, cnt <= cnt+1, err |= range flag.
    - Terminate the operand when in_last=1 OR cnt+1 == NUM_TERMS, whichever comes first.
    - On termination go to DONE.
    - Set err if in_last and cnt+1 != NUM_TERMS (early last).
    - Set err if cnt+1 == NUM_TERMS without in_last (missing last).
  - DONE:
    - in_ready=0, out_valid=1.
    - out_residue=acc, out_err=err; both held stable while out_valid=1 and out_ready=0.
    - On output transfer: out_valid<=0, cnt<=0, err<=0, go to IDLE.
- Latency and throughput:
  - Result is valid the cycle after the terminating term is accepted.
  - One term per cycle while accumulating.
  - One dead cycle per operand for output transfer; no overlap of input with a pending output.
- Stalls: in_valid=0 in ACC holds acc and cnt with no timeout.
- rst asserted at any cycle, including mid-operand or while out_valid=1:
  - Next cycle is in the reset state.
  - The partial sum is discarded and no output beat is produced.
- Outputs are registered; no combinational path from in_* to out_*. in_ready is decoded from state only.

Test Plan:
- NUM_TERMS=3; terms 460, 460, 460 with in_last on the third -> out_residue=458, out_err=0, out_valid exactly 1 cycle after the third accept.
- Default params; 67 terms of value 1, in_last on the 67th, back-to-back with in_valid held high -> out_residue=67, out_err=0, in_ready=0 for the DONE cycle.
- NUM_TERMS=3; terms 511, 0, 10, last on the third -> out_residue=60 (511 pre-reduced to 50), out_err=1.
- NUM_TERMS=3; terms 5, 7 with in_last on the second -> out_residue=12, out_err=1. Separately, terms 1, 2, 3 with no in_last -> out_residue=6, out_err=1, and the block returns to IDLE after the output transfer.
- out_ready=0 for 5 cycles after a result -> out_valid, out_residue and out_err stable; in_ready=0; in_valid beats ignored; the next operand starts accumulating from 0 after the transfer.
- rst pulsed after 2 of 3 terms, then a fresh operand 100, 200, 300 -> out_residue=139, out_err=0, with no spurious out_valid before it.
